prog_load_ram: RTL and testbench

//  Parametrised program/data memory with a built-in loader FSM; replaces ad-hoc input_mode/address/program poking.

---
 rtl/prog_load_ram_pkg.sv | 23 ++
 rtl/prog_load_ram_mem_array.sv | 43 ++++
 rtl/prog_load_ram.sv | 164 ++++++++++++++++
 tb/tb_prog_load_ram.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_load_ram_pkg.sv
// +----------------------------------------------------------------------------+
// | prog_load_pkg : shared state encodings and sizing helper for prog_load_ram |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package prog_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CSUM = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } ld_state_t;

  function automatic int unsigned depth_f(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_load_ram_mem_array.sv
// +----------------------------------------------------------------------------+
// | prog_mem_array : single write port storage with registered read port       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module prog_mem_array #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read samples the array before this edge's write lands, so rd+wr to one address returns old data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/prog_load_ram.sv
// +----------------------------------------------------------------------------+
// | prog_load_ram : program/data RAM with host loader FSM gating CPU access.    |
// | Optional checksum word after load_last: define PROG_LOAD_CHECKSUM_EN.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module prog_load_ram
  import prog_load_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic              cpu_run,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wdata
);

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(depth_f(ADDR_W));

  ld_state_t         r_state;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_count;
  logic              r_load_ready;
  logic              r_load_done;
  logic              r_load_err;
  logic              r_cpu_run;
`ifdef PROG_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
`endif

  logic              w_hs;
  logic              w_full;
  logic              w_ld_we;
  logic              w_cpu_we;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_re;

  assign w_hs     = load_valid & r_load_ready;
  assign w_full   = (r_count == c_DEPTH);
  // A restart or reset on the same edge wins over any pending write.
  assign w_ld_we  = reset & ~load_start & (r_state == ST_LOAD) & w_hs & ~w_full;
  assign w_cpu_we = reset & ~load_start & (r_state == ST_RUN) & cpu_wr;
  assign w_we     = w_ld_we | w_cpu_we;
  assign w_waddr  = (r_state == ST_LOAD) ? r_wptr : cpu_addr;
  assign w_wdata  = (r_state == ST_LOAD) ? load_data : cpu_wdata;
  assign w_re     = (r_state == ST_RUN) & cpu_rd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_wptr       <= '0;
      r_count      <= '0;
      r_load_ready <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_cpu_run    <= 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else if (load_start) begin
      r_state      <= ST_LOAD;
      r_wptr       <= load_base;
      r_count      <= '0;
      r_load_ready <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_cpu_run    <= 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_LOAD: begin
          if (w_hs) begin
            if (w_full) begin
              r_state      <= ST_ERR;
              r_load_ready <= 1'b0;
              r_load_err   <= 1'b1;
            end else begin
              r_wptr  <= r_wptr + ADDR_W'(1);
              r_count <= r_count + (ADDR_W+1)'(1);
`ifdef PROG_LOAD_CHECKSUM_EN
              r_sum   <= r_sum + load_data;
              if (load_last) begin
                r_state <= ST_CSUM;
              end
`else
              if (load_last) begin
                r_state      <= ST_RUN;
                r_load_ready <= 1'b0;
                r_load_done  <= 1'b1;
                r_cpu_run    <= 1'b1;
              end
`endif
            end
          end
        end
`ifdef PROG_LOAD_CHECKSUM_EN
        ST_CSUM: begin
          if (w_hs) begin
            r_load_ready <= 1'b0;
            if (load_data == r_sum) begin
              r_state     <= ST_RUN;
              r_load_done <= 1'b1;
              r_cpu_run   <= 1'b1;
            end else begin
              r_state    <= ST_ERR;
              r_load_err <= 1'b1;
            end
          end
        end
`endif
        ST_RUN: ;
        ST_ERR: ;
        default: begin
          r_state      <= ST_IDLE;
          r_load_ready <= 1'b0;
          r_load_done  <= 1'b0;
          r_load_err   <= 1'b0;
          r_cpu_run    <= 1'b0;
        end
      endcase
    end
  end

  prog_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (cpu_addr),
    .o_rdata (cpu_rdata)
  );

  assign load_ready = r_load_ready;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;
  assign cpu_run    = r_cpu_run;

endmodule

`default_nettype wire

// File: tb/tb_prog_load_ram.sv
// +----------------------------------------------------------------------------+
// | tb_prog_load_ram : directed bench with read-data scoreboard                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_prog_load_ram;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic [3:0] load_base;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       load_done;
  logic       load_err;
  logic       cpu_run;
  logic [3:0] cpu_addr;
  logic       cpu_rd;
  logic [7:0] cpu_rdata;
  logic       cpu_wr;
  logic [7:0] cpu_wdata;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] model [16];
  logic [7:0] exp_q [$];
  logic [7:0] wq [$];
  logic [7:0] last_rd;

  always #5 clk = ~clk;

  prog_load_ram #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_base  (load_base),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_err   (load_err),
    .cpu_run    (cpu_run),
    .cpu_addr   (cpu_addr),
    .cpu_rd     (cpu_rd),
    .cpu_rdata  (cpu_rdata),
    .cpu_wr     (cpu_wr),
    .cpu_wdata  (cpu_wdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    exp_q.push_back(model[a]);
    tick;
    cpu_rd = 1'b0;
    chk($sformatf("rdata[%0h]", a), cpu_rdata, exp_q.pop_front());
    last_rd = cpu_rdata;
  endtask

  // Streams wq from base; with_last tags the final word (and sends a checksum when enabled).
  task automatic load_words(input logic [3:0] base, input bit with_last);
    logic [3:0] p;
    logic [7:0] s;
    int         cnt;
    p   = base;
    s   = 8'h00;
    cnt = 0;
    load_base  = base;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    chk("start_ready", load_ready, 1);
    chk("start_run_low", cpu_run, 0);
    chk("start_err_low", load_err, 0);
    foreach (wq[i]) begin
      load_valid = 1'b1;
      load_data  = wq[i];
      load_last  = with_last && (i == wq.size() - 1);
      if (cnt < 16) begin
        model[p] = wq[i];
        p        = p + 4'd1;
        s        = s + wq[i];
      end
      cnt++;
      tick;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
    if (with_last) begin
      load_valid = 1'b1;
      load_data  = s;
      tick;
      load_valid = 1'b0;
    end
`endif
  endtask

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    load_base  = 4'h0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    cpu_addr   = 4'h0;
    cpu_rd     = 1'b0;
    cpu_wr     = 1'b0;
    cpu_wdata  = 8'h00;
    last_rd    = 8'h00;
    tick;
    tick;
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_rdata", cpu_rdata, 8'h00);
    reset = 1'b1;
    tick;
    chk("idle_ready", load_ready, 0);

    // Fill all DEPTH words exactly; the 16th carries last and must not overflow.
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(8'(8'h10 + i * 3));
    load_words(4'h0, 1'b1);
    chk("full_run", cpu_run, 1);
    chk("full_done", load_done, 1);
    chk("full_ready", load_ready, 0);
    rd(4'hF);

    // Test 1: two words at base 9.
    wq = {8'h01, 8'h08};
    load_words(4'h9, 1'b1);
    chk("t1_run", cpu_run, 1);
    rd(4'h9);
    rd(4'hA);

    // Test 2: write 0x5C to 3 with a simultaneous read of the old value.
    cpu_addr  = 4'h3;
    cpu_wr    = 1'b1;
    cpu_wdata = 8'h5C;
    cpu_rd    = 1'b1;
    exp_q.push_back(model[3]);
    model[3]  = 8'h5C;
    tick;
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    chk("t2_rdwr_old", cpu_rdata, exp_q.pop_front());
    rd(4'h3);

    // Test 3: wrap from F to 0.
    wq = {8'h11, 8'h22, 8'h33};
    load_words(4'hF, 1'b1);
    chk("t3_run", cpu_run, 1);
    rd(4'hF);
    rd(4'h0);
    rd(4'h1);

    // Test 4: 17 words, no last -> overflow.
    wq.delete();
    for (int i = 0; i < 17; i++) wq.push_back(8'(8'h40 + i));
    load_words(4'h0, 1'b0);
    chk("t4_err", load_err, 1);
    chk("t4_run", cpu_run, 0);
    chk("t4_ready", load_ready, 0);
    cpu_addr = 4'h5;
    cpu_rd   = 1'b1;
    cpu_wr   = 1'b1;
    cpu_wdata = 8'hEE;
    tick;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    chk("t4_rd_ignored", cpu_rdata, last_rd);

    // Test 5: restart from ERR, two words, then reset mid-load.
    load_base  = 4'h4;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    chk("t5_ready", load_ready, 1);
    chk("t5_err_clr", load_err, 0);
    load_valid = 1'b1;
    load_data  = 8'hA1;
    model[4]   = 8'hA1;
    tick;
    load_data  = 8'hA2;
    model[5]   = 8'hA2;
    tick;
    load_valid = 1'b0;
    reset      = 1'b0;
    tick;
    reset = 1'b1;
    chk("t5_rst_ready", load_ready, 0);
    chk("t5_rst_run", cpu_run, 0);
    chk("t5_rst_rdata", cpu_rdata, 8'h00);
    wq = {8'h77};
    load_words(4'h0, 1'b1);
    chk("t5_run", cpu_run, 1);
    rd(4'h0);
    rd(4'h4);
    rd(4'h5);
    rd(4'h6);
    rd(4'hF);

`ifdef PROG_LOAD_CHECKSUM_EN
    // Test 6: bad checksum leaves the words written but lands in ERR.
    load_base  = 4'h9;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'h03;
    model[9]   = 8'h03;
    tick;
    load_data  = 8'h0C;
    load_last  = 1'b1;
    model[10]  = 8'h0C;
    tick;
    load_last  = 1'b0;
    chk("t6_csum_ready", load_ready, 1);
    load_data  = 8'h10;
    tick;
    load_valid = 1'b0;
    chk("t6_bad_err", load_err, 1);
    chk("t6_bad_run", cpu_run, 0);
    wq = {8'h55};
    load_words(4'h0, 1'b1);
    chk("t6_good_run", cpu_run, 1);
    rd(4'h9);
    rd(4'hA);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
